// File: rtl/reconfig_request_seq_if.sv
// Avalon-MM register-slave bus for reconfig_request_seq. Fixed timing: a write occurs
// on any rising edge with chipselect=1 and write_n=0; readdata shows the register
// selected by address one cycle later. There is no waitrequest and no back-pressure.
interface reconfig_request_seq_if #(
   parameter int CNT_W = 16
);
   logic [1:0]       address;
   logic             chipselect;
   logic             write_n;
   logic [CNT_W-1:0] writedata;
   logic [CNT_W-1:0] readdata;

   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/reconfig_request_seq.sv
// Qualifies a synchronised reconfig request for hold+1 cycles, then drives a glitch-free
// active-low reconfig pulse. Optional interrupt output: define RECONFIG_REQ_IRQ_EN.
module reconfig_request_seq #(
   parameter int               CNT_W     = 16,
   parameter logic [CNT_W-1:0] HOLD_RST  = CNT_W'(16'h00FF),
   parameter logic [CNT_W-1:0] PULSE_RST = CNT_W'(16'h0010)
) (
   input  logic                 clk,
   input  logic                 reset,
   reconfig_request_seq_if.slave bus,
   input  logic                 req_in,
   output logic                 reconfig_n,
   output logic                 busy,
   output logic                 irq,
   output logic [1:0]           state_dbg
);
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_QUALIFY = 2'd1,
      S_PULSE   = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic             req_m, req_s;
   logic [CNT_W-1:0] hold_q, pulse_q, cnt_q, cnt_d;
   logic             arm_q, done_q, abort_q, done_d, abort_d;
   logic             set_done, set_abort;
   logic             irq_en_q;
   logic             wr_en, ctrl_wr, clr;
   logic [CNT_W-1:0] rd_mux;

   assign wr_en   = bus.chipselect & ~bus.write_n;
   assign ctrl_wr = wr_en && (bus.address == 2'd3);
   assign clr     = ctrl_wr && bus.writedata[1];

   assign busy       = (state_q != S_IDLE);
   assign reconfig_n = (state_q != S_PULSE);
   assign state_dbg  = state_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      set_done  = 1'b0;
      set_abort = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (arm_q && req_s) begin
               state_d = S_QUALIFY;
               cnt_d   = hold_q;
            end
         end
         S_QUALIFY: begin
            if (!req_s || !arm_q) begin
               state_d   = S_IDLE;
               set_abort = 1'b1;
            end else if (cnt_q == '0) begin
               state_d = S_PULSE;
               cnt_d   = (pulse_q == '0) ? ONE : pulse_q;
            end else begin
               cnt_d = cnt_q - ONE;
            end
         end
         S_PULSE: begin
            // Request and arm are deliberately ignored once the pulse has started.
            if (cnt_q <= ONE) begin
               state_d  = S_DONE;
               set_done = 1'b1;
            end
            if (cnt_q != '0) cnt_d = cnt_q - ONE;
         end
         S_DONE: begin
            if (!req_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Sticky flags: a set in the same cycle as a clear write takes priority.
   assign done_d  = set_done  | (done_q  & ~clr);
   assign abort_d = set_abort | (abort_q & ~clr);

   always_comb begin
      rd_mux = '0;
      case (bus.address)
         2'd0: begin
            rd_mux[0]   = busy;
            rd_mux[1]   = done_q;
            rd_mux[2]   = abort_q;
            rd_mux[3]   = req_s;
            rd_mux[4]   = irq_en_q;
            rd_mux[7:5] = {1'b0, state_q};
         end
         2'd1: rd_mux = hold_q;
         2'd2: rd_mux = pulse_q;
         default: begin
            rd_mux[0] = arm_q;
            rd_mux[2] = irq_en_q;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         req_m        <= 1'b0;
         req_s        <= 1'b0;
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         hold_q       <= HOLD_RST;
         pulse_q      <= PULSE_RST;
         arm_q        <= 1'b0;
         done_q       <= 1'b0;
         abort_q      <= 1'b0;
         bus.readdata <= '0;
      end else begin
         req_m   <= req_in;
         req_s   <= req_m;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         // Timing registers are frozen while a sequence is in flight.
         if (wr_en && !busy) begin
            if (bus.address == 2'd1) hold_q  <= bus.writedata;
            if (bus.address == 2'd2) pulse_q <= bus.writedata;
         end
         if (ctrl_wr) arm_q <= bus.writedata[0];
         done_q       <= done_d;
         abort_q      <= abort_d;
         bus.readdata <= rd_mux;
      end
   end

`ifdef RECONFIG_REQ_IRQ_EN
   logic irq_en_d;
   logic irq_q;

   assign irq_en_d = ctrl_wr ? bus.writedata[2] : irq_en_q;

   // Registered from next-state values so a clear takes effect on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         irq_en_q <= irq_en_d;
         irq_q    <= irq_en_d & (done_d | abort_d);
      end
   end

   assign irq = irq_q;
`else
   assign irq_en_q = 1'b0;
   assign irq      = 1'b0;
`endif

endmodule

// File: tb/tb_reconfig_request_seq.sv
// Self-checking bench for reconfig_request_seq: register vector table plus hand-written
// multi-cycle sequences; read results flow through an expected-value queue.
module tb_reconfig_request_seq;
   logic       clk = 1'b0;
   logic       reset;
   logic       req_in;
   logic       reconfig_n;
   logic       busy;
   logic       irq;
   logic [1:0] state_dbg;

   reconfig_request_seq_if #(.CNT_W(16)) bus ();

   reconfig_request_seq #(
      .CNT_W    (16),
      .HOLD_RST (16'h00FF),
      .PULSE_RST(16'h0010)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus.slave),
      .req_in    (req_in),
      .reconfig_n(reconfig_n),
      .busy      (busy),
      .irq       (irq),
      .state_dbg (state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

`ifdef RECONFIG_REQ_IRQ_EN
   localparam logic [15:0] IE  = 16'h0010;  // status bit4
   localparam logic [15:0] CE  = 16'h0004;  // control bit2
   localparam logic [15:0] IRQ = 16'h0001;  // irq once done is set
`else
   localparam logic [15:0] IE  = 16'h0000;
   localparam logic [15:0] CE  = 16'h0000;
   localparam logic [15:0] IRQ = 16'h0000;
`endif

   int          checks   = 0;
   int          failures = 0;
   logic [15:0] exp_q[$];
   string       name_q[$];

   typedef struct packed {
      logic        do_wr;
      logic [1:0]  addr;
      logic [15:0] wdata;
      logic [15:0] exp;
   } vec_t;
   vec_t tbl[11];

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset          = 1'b1;
      req_in         = 1'b0;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // ---------------- driver tasks ----------------
   task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
      @(negedge clk);
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      bus.address    = a;
      bus.writedata  = d;
      @(negedge clk);
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
   endtask

   // ---------------- scoreboard ----------------
   task automatic bus_read(input logic [1:0] a, input logic [15:0] exp, input string nm);
      exp_q.push_back(exp);
      name_q.push_back(nm);
      @(negedge clk);
      bus.address = a;
      @(negedge clk);
      check(name_q.pop_front(), bus.readdata, exp_q.pop_front());
   endtask

   // Counts edges from the first one that samples a new req_in (edge 1).
   task automatic watch(input int n, output int first, output int lows);
      first = -1;
      lows  = 0;
      for (int k = 1; k <= n; k++) begin
         @(posedge clk);
         #1;
         if (!reconfig_n) begin
            lows++;
            if (first < 0) first = k;
         end
      end
   endtask

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int first, lows;
      bit found;

      reset          = 1'b1;
      req_in         = 1'b0;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.address    = 2'd0;
      bus.writedata  = 16'h0000;

      tbl[0]  = '{1'b0, 2'd0, 16'h0000, 16'h0000};
      tbl[1]  = '{1'b0, 2'd1, 16'h0000, 16'h00FF};
      tbl[2]  = '{1'b0, 2'd2, 16'h0000, 16'h0010};
      tbl[3]  = '{1'b0, 2'd3, 16'h0000, 16'h0000};
      tbl[4]  = '{1'b1, 2'd1, 16'h1234, 16'h1234};
      tbl[5]  = '{1'b1, 2'd2, 16'hABCD, 16'hABCD};
      tbl[6]  = '{1'b1, 2'd3, 16'h0007, 16'h0001 | CE};
      tbl[7]  = '{1'b0, 2'd0, 16'h0000, IE};
      tbl[8]  = '{1'b1, 2'd3, 16'h0000, 16'h0000};
      tbl[9]  = '{1'b1, 2'd0, 16'hFFFF, 16'h0000};
      tbl[10] = '{1'b1, 2'd1, 16'h0000, 16'h0000};

      // Reset state
      do_reset();
      check("rst_reconfig_n", 16'(reconfig_n), 16'h0001);
      check("rst_busy",       16'(busy),       16'h0000);
      check("rst_irq",        16'(irq),        16'h0000);
      check("rst_readdata",   bus.readdata,    16'h0000);

      // Register vector table
      for (int i = 0; i < 11; i++) begin
         if (tbl[i].do_wr) bus_write(tbl[i].addr, tbl[i].wdata);
         bus_read(tbl[i].addr, tbl[i].exp, $sformatf("vec%0d", i));
      end

      // Full sequence: hold=4, pulse=3
      do_reset();
      bus_write(2'd1, 16'h0004);
      bus_write(2'd2, 16'h0003);
      bus_write(2'd3, 16'h0001 | CE);
      @(negedge clk);
      req_in = 1'b1;
      watch(20, first, lows);
      check("seq_first_low", 16'(first), 16'd8);
      check("seq_low_cycles", 16'(lows), 16'd3);
      check("seq_busy_done", 16'(busy), 16'h0001);
      check("seq_irq_set", 16'(irq), IRQ);
      bus_read(2'd0, 16'h006B | IE, "seq_status_done");
      bus_write(2'd1, 16'h0020);
      bus_read(2'd1, 16'h0004, "hold_locked_busy");
      bus_write(2'd3, 16'h0003 | CE);
      check("seq_irq_clr", 16'(irq), 16'h0000);
      bus_read(2'd0, 16'h0069 | IE, "seq_status_clr");
      @(negedge clk);
      req_in = 1'b0;
      repeat (4) @(negedge clk);
      check("seq_back_idle", 16'(state_dbg), 16'h0000);
      bus_read(2'd0, IE, "seq_status_idle");

      // Abort: hold=10, request dropped after 5 cycles
      do_reset();
      bus_write(2'd1, 16'd10);
      bus_write(2'd3, 16'h0001);
      @(negedge clk);
      req_in = 1'b1;
      lows = 0;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk);
         #1;
         if (!reconfig_n) lows++;
         if (k == 5) req_in = 1'b0;
      end
      check("abort_no_pulse", 16'(lows), 16'h0000);
      check("abort_state", 16'(state_dbg), 16'h0000);
      check("abort_irq", 16'(irq), 16'h0000);
      bus_read(2'd0, 16'h0004, "abort_status");
      bus_write(2'd3, 16'h0003);
      bus_read(2'd0, 16'h0000, "abort_cleared");
      bus_read(2'd3, 16'h0001, "ctrl_clear_reads0");

      // Minimum timing: hold=0, pulse=0
      do_reset();
      bus_write(2'd1, 16'h0000);
      bus_write(2'd2, 16'h0000);
      bus_write(2'd3, 16'h0001);
      @(negedge clk);
      req_in = 1'b1;
      watch(15, first, lows);
      check("min_first_low", 16'(first), 16'd4);
      check("min_low_cycles", 16'(lows), 16'd1);
      bus_read(2'd0, 16'h006B, "min_status_done");

      // Reset during the pulse
      do_reset();
      bus_write(2'd1, 16'h0004);
      bus_write(2'd2, 16'h0003);
      bus_write(2'd3, 16'h0001);
      @(negedge clk);
      req_in = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         if (!reconfig_n) found = 1'b1;
      end
      check("pulse_reached", 16'(found), 16'h0001);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_reconfig_n", 16'(reconfig_n), 16'h0001);
      check("mid_rst_busy", 16'(busy), 16'h0000);
      check("mid_rst_readdata", bus.readdata, 16'h0000);
      reset = 1'b0;
      bus_read(2'd1, 16'h00FF, "mid_rst_hold");
      repeat (8) @(negedge clk);
      check("mid_rst_no_retrigger", 16'(reconfig_n), 16'h0001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/reconfig_request_seq.md
RECONFIG_REQUEST_SEQ -- requirements
Module: reconfig_request_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of hold/pulse counters and registers.
REQ-002 SHALL have parameter HOLD_RST, default 16'h00FF, reset value of hold register.
REQ-003 SHALL have parameter PULSE_RST, default 16'h0010, reset value of pulse register.
REQ-004 SHALL have port clk  in  1  single clock; one clock, all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port address  in  2  Avalon-MM register select.
REQ-007 SHALL have port chipselect  in  1  Avalon select.
REQ-008 SHALL have port write_n  in  1  active-low write strobe.
REQ-009 SHALL have port writedata  in  CNT_W  write data.
REQ-010 SHALL have port readdata  out  CNT_W  registered read data.
REQ-011 SHALL have port req_in  in  1  asynchronous reconfig-request level from the request PIO pin.
REQ-012 SHALL have port reconfig_n  out  1  active-low reconfiguration pulse.
REQ-013 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-014 SHALL have port irq  out  1  level interrupt (see Configuration).

Function
REQ-015 SHALL synchronise req_in through two flops to req_s; no other logic uses req_in.
REQ-016 SHALL map registers: 0 status (RO), 1 hold (RW), 2 pulse (RW), 3 control (RW).
REQ-017 Status SHALL read: bit0 busy, bit1 done, bit2 abort, bit3 req_s, bit4 irq_en, bits7:5 state code, upper bits 0.
REQ-018 Control SHALL be: bit0 arm (RW), bit1 clear (write-1 clears done and abort, reads 0), bit2 irq_en (RW).
REQ-019 readdata SHALL register the selected value every cycle (1-cycle read latency, independent of chipselect).
REQ-020 Writes to hold or pulse while busy=1 SHALL be ignored.
REQ-021 FSM states, codes: IDLE=0, QUALIFY=1, PULSE=2, DONE=3.
REQ-022 IDLE: arm=1 and req_s=1 -> QUALIFY, counter loaded with hold.
REQ-023 QUALIFY: req_s=0 or arm=0 -> IDLE, abort set; else counter==0 -> PULSE with counter loaded with max(pulse,1); else decrement. QUALIFY lasts hold+1 cycles.
REQ-024 PULSE: reconfig_n=0; counter==1 -> DONE, else decrement; reconfig_n low exactly max(pulse,1) cycles; arm and req_s ignored.
REQ-025 DONE: done set; stays until req_s=0, then IDLE (no retrigger while request held).
REQ-026 reconfig_n SHALL be decoded only from the state register (glitch-free), high in all states but PULSE.
REQ-027 Simultaneous clear write and done/abort set in same cycle: set wins.
REQ-028 Counter SHALL not wrap; decrement occurs only when nonzero.

Reset
REQ-029 On reset: state IDLE, reconfig_n=1, busy=0, irq=0, readdata=0, sync flops 0, arm=0, irq_en=0, done=0, abort=0, hold=HOLD_RST, pulse=PULSE_RST, counter=0.
REQ-030 Reset asserted during PULSE SHALL return reconfig_n to 1 on the next edge.

Configuration
REQ-031 Macro RECONFIG_REQ_IRQ_EN defined: irq = irq_en & (done | abort), registered.
REQ-032 Macro undefined: irq tied 0, control bit2 not stored, status bit4 and control bit2 read 0.

Verification
REQ-033 hold=4, pulse=3, arm=1, req_in held 1 -> reconfig_n low exactly 3 cycles; first low cycle follows 8th edge counting first req_in sampling edge as 1st; then done=1.
REQ-034 hold=10, arm=1, req_in high 5 cycles then low -> no reconfig_n pulse, abort=1, state IDLE; write control=0x3 -> abort=0.
REQ-035 pulse=0, hold=0 -> reconfig_n low exactly 1 cycle.
REQ-036 Write hold=0x20 while busy -> read hold returns prior value 0x0004 one cycle after read address.
REQ-037 Assert reset for 1 cycle in PULSE -> reconfig_n=1, busy=0, hold=0x00FF next cycle.
REQ-038 With RECONFIG_REQ_IRQ_EN, irq_en=1, scenario REQ-033 -> irq=1 after done; clear write -> irq=0 next cycle; without macro irq stays 0.
